regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Arbitrates the single register-file write port between CPU
//            writeback and a debug port, with a bounded debug starvation
//            window, and provides a zero-fill sweep of the whole file.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int REG_COUNT    = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = $clog2(REG_COUNT),
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  dbg_ack,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  rf_writeEn,
    output logic [ADDR_WIDTH-1:0] rf_writeAddr,
    output logic [DATA_WIDTH-1:0] rf_writeData
);

    // Starvation counter is at least 3 bits, wider if the limit needs it.
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(REG_COUNT - 1);
    localparam logic [CNT_W-1:0]      STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [0:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q,    clr_ptr_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;

    logic force_dbg;

    // A debug request that has lost arbitration STARVE_LIMIT times wins outright.
    assign force_dbg = dbg_req && (starve_cnt_q == STARVE_MAX);

    // Next-state logic and the combinational write-port mux.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        cpu_stall    = 1'b0;
        dbg_ack      = 1'b0;
        busy         = 1'b0;
        rf_writeEn   = 1'b0;
        rf_writeAddr = '0;
        rf_writeData = '0;

        if (state_q == ST_CLEAR) begin
            // Sweep owns the port; requests wait. clr_start cannot restart it.
            busy         = 1'b1;
            rf_writeEn   = 1'b1;
            rf_writeAddr = clr_ptr_q;
            cpu_stall    = cpu_we;
            starve_cnt_d = '0;
            if (clr_ptr_q == LAST_ADDR) begin
                state_d   = ST_RUN;
                clr_ptr_d = '0;
            end else begin
                clr_ptr_d = clr_ptr_q + 1'b1;
            end
        end else begin
            if (force_dbg) begin
                rf_writeEn   = 1'b1;
                rf_writeAddr = dbg_addr;
                rf_writeData = dbg_data;
                dbg_ack      = 1'b1;
                cpu_stall    = cpu_we;
                starve_cnt_d = '0;
            end else if (cpu_we) begin
                rf_writeEn   = 1'b1;
                rf_writeAddr = cpu_addr;
                rf_writeData = cpu_data;
                if (dbg_req) begin
                    if (starve_cnt_q < STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end else if (dbg_req) begin
                rf_writeEn   = 1'b1;
                rf_writeAddr = dbg_addr;
                rf_writeData = dbg_data;
                dbg_ack      = 1'b1;
                starve_cnt_d = '0;
            end else begin
                starve_cnt_d = '0;
            end

            // This cycle's arbitration still completes; the sweep starts next cycle.
            if (clr_start) begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        end
    end

    // State registers; reset always lands in a fresh sweep from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int REG_COUNT  = 16;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    logic                  clk;
    logic                  rst;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_data;
    logic                  cpu_stall;
    logic                  dbg_req;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_data;
    logic                  dbg_ack;
    logic                  clr_start;
    logic                  busy;
    logic                  rf_writeEn;
    logic [ADDR_WIDTH-1:0] rf_writeAddr;
    logic [DATA_WIDTH-1:0] rf_writeData;

    int n_total;
    int n_bad;

    regfile_write_arbiter #(
        .REG_COUNT    (REG_COUNT),
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_stall    (cpu_stall),
        .dbg_req      (dbg_req),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .dbg_ack      (dbg_ack),
        .clr_start    (clr_start),
        .busy         (busy),
        .rf_writeEn   (rf_writeEn),
        .rf_writeAddr (rf_writeAddr),
        .rf_writeData (rf_writeData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs just after the falling edge and let them settle.
    task automatic drive(input logic we, input logic [3:0] ca, input logic [7:0] cd,
                         input logic dr, input logic [3:0] da, input logic [7:0] dd,
                         input logic cs);
        cpu_we    = we;
        cpu_addr  = ca;
        cpu_data  = cd;
        dbg_req   = dr;
        dbg_addr  = da;
        dbg_data  = dd;
        clr_start = cs;
        #1;
    endtask

    // Compare every output of the current cycle.
    task automatic expect_out(input string tag, input logic b, input logic we,
                              input logic [3:0] a, input logic [7:0] d,
                              input logic ack, input logic stall);
        chk({tag, ".busy"},  {31'd0, busy},        {31'd0, b});
        chk({tag, ".we"},    {31'd0, rf_writeEn},  {31'd0, we});
        chk({tag, ".addr"},  {28'd0, rf_writeAddr}, {28'd0, a});
        chk({tag, ".data"},  {24'd0, rf_writeData}, {24'd0, d});
        chk({tag, ".ack"},   {31'd0, dbg_ack},     {31'd0, ack});
        chk({tag, ".stall"}, {31'd0, cpu_stall},   {31'd0, stall});
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        drive(1'b1, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);

        // Reset holds the sweep at address 0; stall mirrors cpu_we.
        repeat (2) @(negedge clk);
        #1;
        expect_out("reset", 1'b1, 1'b1, 4'd0, 8'd0, 1'b0, 1'b1);

        // Release and watch the full 16-cycle zero sweep.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
            expect_out($sformatf("sweep%0d", i), 1'b1, 1'b1, 4'(i), 8'd0, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
        expect_out("post_sweep", 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Plain CPU write.
        drive(1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 8'd0, 1'b0);
        expect_out("cpu_only", 1'b0, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0);
        @(negedge clk);

        // Debug alone is acknowledged immediately.
        drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd9, 8'h11, 1'b0);
        expect_out("dbg_only", 1'b0, 1'b1, 4'd9, 8'h11, 1'b1, 1'b0);
        @(negedge clk);

        // Idle cycle with stale address/data on the inputs: port fully zero.
        drive(1'b0, 4'd6, 8'hEE, 1'b0, 4'd8, 8'hDD, 1'b0);
        expect_out("idle", 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Contention: CPU wins 4 times, debug forced on the 5th, CPU again on the 6th.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd2, 8'h44, 1'b1, 4'd7, 8'hC3, 1'b0);
            expect_out($sformatf("starve%0d", i), 1'b0, 1'b1, 4'd2, 8'h44, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 4'd2, 8'h44, 1'b1, 4'd7, 8'hC3, 1'b0);
        expect_out("forced", 1'b0, 1'b1, 4'd7, 8'hC3, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 4'd2, 8'h45, 1'b0, 4'd7, 8'hC3, 1'b0);
        expect_out("after_force", 1'b0, 1'b1, 4'd2, 8'h45, 1'b0, 1'b0);
        @(negedge clk);

        // Same address on both sides: only the CPU write happens.
        drive(1'b1, 4'd5, 8'hAA, 1'b1, 4'd5, 8'hBB, 1'b0);
        expect_out("same_addr", 1'b0, 1'b1, 4'd5, 8'hAA, 1'b0, 1'b0);
        @(negedge clk);

        // Clear request: CPU write still lands this cycle, then a 16-cycle sweep
        // that ignores a second clr_start and blocks both requesters.
        drive(1'b1, 4'd4, 8'h77, 1'b0, 4'd0, 8'd0, 1'b1);
        expect_out("clr_cycle", 1'b0, 1'b1, 4'd4, 8'h77, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < REG_COUNT; i++) begin
            drive(1'b1, 4'd4, 8'h77, 1'b1, 4'd1, 8'h99, (i == 5));
            expect_out($sformatf("clr%0d", i), 1'b1, 1'b1, 4'(i), 8'd0, 1'b0, 1'b1);
            @(negedge clk);
        end
        drive(1'b1, 4'd4, 8'h78, 1'b0, 4'd0, 8'd0, 1'b0);
        expect_out("clr_done", 1'b0, 1'b1, 4'd4, 8'h78, 1'b0, 1'b0);
        @(negedge clk);

        // Reset in the middle of a sweep restarts it from address 0.
        drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
        expect_out("pre_rst9", 1'b1, 1'b1, 4'd9, 8'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        expect_out("rst9", 1'b1, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
            expect_out($sformatf("resweep%0d", i), 1'b1, 1'b1, 4'(i), 8'd0, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
        expect_out("resweep_done", 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
